mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// +--------------------------------------------------------------------------+
// | mem_access_unit : wait-stated single-port 16-bit word array for a CPU    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_access_unit #(
   parameter int WAIT_CYCLES = 2,
   parameter int DEPTH       = 128
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        Req,
   input  logic        We,
   input  logic [7:0]  Addr,
   input  logic [15:0] WData,
   output logic        Ready,
   output logic        Ack,
   output logic [15:0] RData,
   output logic        Err
);

   localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [8:0] DEPTH_L = 9'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACCESS = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [7:0]    addr_q, addr_d;
   logic          we_q, we_d;
   logic [15:0]   wdata_q, wdata_d;
   logic [15:0]   rdata_q, rdata_d;
   logic          err_q, err_d;

   logic [15:0]   mem [DEPTH];
   logic          in_range;
   logic [AW-1:0] idx;

   assign in_range = ({1'b0, addr_q} < DEPTH_L);
   assign idx      = addr_q[AW-1:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (Req) begin
               addr_d  = Addr;
               we_d    = We;
               wdata_d = WData;
               err_d   = 1'b0;
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
            end
         end
         S_WAIT: begin
            // Leave on the edge that brings the counter to zero.
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               state_d = S_ACCESS;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ACCESS: begin
            if (!we_q) begin
               rdata_d = in_range ? mem[idx] : 16'h0000;
            end
            err_d   = !in_range;
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 8'h00;
         we_q    <= 1'b0;
         wdata_q <= 16'h0000;
         rdata_q <= 16'h0000;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Array survives reset; an asserted reset has already forced IDLE, so no write slips through.
   always_ff @(posedge Clk) begin
      if (state_q == S_ACCESS && we_q && in_range) begin
         mem[idx] <= wdata_q;
      end
   end

   assign Ready = (state_q == S_IDLE);
   assign Ack   = (state_q == S_DONE);
   assign RData = rdata_q;
   assign Err   = err_q;

endmodule

`default_nettype wire
